alu_exec_wb: RTL and testbench



---
 rtl/alu_exec_wb.sv | 174 +++++++++++++++++
 tb/tb_alu_exec_wb.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_wb.sv
// Execute/write-back stage around the combinational 8-bit ALU: decodes instruction bytes,
// feeds the ALU from a 4-entry register file and retires T/Cf/Zf into the registers and flags.
module alu_exec_wb #(
    parameter int DW             = 8,
    parameter bit NOP_ON_ILLEGAL = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    ins,
    input  logic          ins_valid,
    output logic          ins_ready,
    output logic          M,
    output logic [3:0]    se,
    output logic [DW-1:0] S,
    output logic [DW-1:0] D,
    input  logic [DW-1:0] T,
    input  logic          Cf,
    input  logic          Zf,
    output logic          CF,
    output logic          ZF,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_data,
    output logic          busy,
    output logic          ill_op
);

    localparam logic [3:0] OP_LDI    = 4'b0000;
    localparam logic [3:0] OP_ADD    = 4'b1001;
    localparam logic [3:0] OP_SUB    = 4'b0110;
    localparam logic [3:0] OP_AND    = 4'b1011;
    localparam logic [3:0] OP_NOT    = 4'b0101;
    localparam logic [3:0] OP_MOVD_A = 4'b1010;
    localparam logic [3:0] OP_MOVD_B = 4'b0100;
    localparam logic [3:0] OP_MOVS   = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IMM,
        ST_EXEC
    } state_t;

    state_t        state_q, state_d;
    logic          m_q, m_d;
    logic [3:0]    se_q, se_d;
    logic [DW-1:0] s_q, s_d;
    logic [DW-1:0] d_q, d_d;
    logic [1:0]    rd_q, rd_d;
    logic [DW-1:0] regs_q [4];
    logic [DW-1:0] regs_d [4];
    logic          cf_q, cf_d;
    logic          zf_q, zf_d;
    logic          ill_q, ill_d;

    logic [3:0]    op_f;
    logic [1:0]    rs_f;
    logic [1:0]    rd_f;
    logic          accept;
    logic          op_alu;
    logic          op_ldi;

    assign op_f   = ins[7:4];
    assign rs_f   = ins[3:2];
    assign rd_f   = ins[1:0];
    assign op_ldi = (op_f == OP_LDI);

    assign ins_ready = (state_q != ST_EXEC);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = ins_valid && ins_ready;

    assign M        = m_q;
    assign se       = se_q;
    assign S        = s_q;
    assign D        = d_q;
    assign CF       = cf_q;
    assign ZF       = zf_q;
    assign ill_op   = ill_q;
    assign dbg_data = regs_q[dbg_sel];

    always_comb begin
        op_alu = 1'b0;
        case (op_f)
            OP_ADD, OP_SUB, OP_AND, OP_NOT,
            OP_MOVD_A, OP_MOVD_B, OP_MOVS: op_alu = 1'b1;
            default:                       op_alu = 1'b0;
        endcase
    end

    // Operands are sampled in IDLE, one cycle after the previous write-back, so no bypass exists.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        se_d    = se_q;
        s_d     = s_q;
        d_d     = d_q;
        rd_d    = rd_q;
        regs_d  = regs_q;
        cf_d    = cf_q;
        zf_d    = zf_q;
        ill_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_alu) begin
                        m_d     = 1'b1;
                        se_d    = op_f;
                        s_d     = regs_q[rs_f];
                        d_d     = regs_q[rd_f];
                        rd_d    = rd_f;
                        state_d = ST_EXEC;
                    end else if (op_ldi) begin
                        rd_d    = rd_f;
                        state_d = ST_IMM;
                    end else begin
                        ill_d = !NOP_ON_ILLEGAL;
                    end
                end
            end
            ST_IMM: begin
                if (accept) begin
                    m_d     = 1'b0;
                    se_d    = 4'd0;
                    s_d     = DW'(ins);
                    d_d     = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                regs_d[rd_q] = T;
                if ((se_q == OP_ADD) || (se_q == OP_SUB)) begin
                    cf_d = Cf;
                    zf_d = Zf;
                end
                m_d     = 1'b0;
                se_d    = 4'd0;
                s_d     = '0;
                d_d     = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            m_q     <= 1'b0;
            se_q    <= 4'd0;
            s_q     <= '0;
            d_q     <= '0;
            rd_q    <= 2'd0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            ill_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            se_q    <= se_d;
            s_q     <= s_d;
            d_q     <= d_d;
            rd_q    <= rd_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
            ill_q   <= ill_d;
            regs_q  <= regs_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_wb.sv
// Scoreboard bench for alu_exec_wb: a behavioural ALU sits beside the stage, and every
// retirement is compared against register/flag snapshots from an instruction-level model.
module tb_alu_exec_wb;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [7:0] ins       = 8'd0;
    logic       ins_valid = 1'b0;
    logic       ins_ready;
    logic       m;
    logic [3:0] se;
    logic [7:0] s_bus;
    logic [7:0] d_bus;
    logic [7:0] alu_t;
    logic       alu_cf;
    logic       alu_zf;
    logic       cf;
    logic       zf;
    logic [1:0] dbg_sel   = 2'd0;
    logic [7:0] dbg_data;
    logic       busy;
    logic       ill_op;

    int n_checks     = 0;
    int n_pass       = 0;
    int ill_expected = 0;
    int ill_seen     = 0;

    logic [7:0] ref_regs [4];
    logic       ref_cf;
    logic       ref_zf;

    typedef struct packed {
        logic [3:0][7:0] regs;
        logic            cf;
        logic            zf;
    } snap_t;

    snap_t sb_q[$];

    logic [3:0] alu_ops [7] = '{4'b1001, 4'b0110, 4'b1011, 4'b0101, 4'b1010, 4'b0100, 4'b1100};
    logic [3:0] ill_ops [8] = '{4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1000, 4'b1101, 4'b1110, 4'b1111};

    always #5 clk = ~clk;

    alu_exec_wb #(
        .DW(8),
        .NOP_ON_ILLEGAL(1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ins      (ins),
        .ins_valid(ins_valid),
        .ins_ready(ins_ready),
        .M        (m),
        .se       (se),
        .S        (s_bus),
        .D        (d_bus),
        .T        (alu_t),
        .Cf       (alu_cf),
        .Zf       (alu_zf),
        .CF       (cf),
        .ZF       (zf),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .busy     (busy),
        .ill_op   (ill_op)
    );

    // Neighbouring combinational ALU; Zf is only asserted when there is no carry.
    always_comb begin
        logic [8:0] wide;
        wide   = 9'd0;
        alu_t  = 8'd0;
        alu_cf = 1'b0;
        if (!m) begin
            alu_t = s_bus;
        end else begin
            case (se)
                4'b1001: begin
                    wide   = {1'b0, d_bus} + {1'b0, s_bus};
                    alu_t  = wide[7:0];
                    alu_cf = wide[8];
                end
                4'b0110: begin
                    alu_t  = d_bus - s_bus;
                    alu_cf = (d_bus < s_bus);
                end
                4'b1011:          alu_t = d_bus & s_bus;
                4'b0101:          alu_t = ~d_bus;
                4'b1010, 4'b0100: alu_t = d_bus;
                4'b1100:          alu_t = s_bus;
                default:          alu_t = 8'd0;
            endcase
        end
        alu_zf = (alu_t == 8'd0) && !alu_cf;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Instruction-level meaning of one ALU opcode: result, whether flags move, and their values.
    function automatic void refExec(input logic [3:0] op, input logic [7:0] src, input logic [7:0] dst,
                                    output logic [7:0] res, output logic upd,
                                    output logic c, output logic z);
        int sum;
        upd = 1'b0;
        c   = 1'b0;
        case (op)
            4'b1001: begin
                sum = int'(dst) + int'(src);
                res = 8'(sum % 256);
                c   = (sum >= 256);
                upd = 1'b1;
            end
            4'b0110: begin
                res = 8'((int'(dst) - int'(src) + 256) % 256);
                c   = (int'(dst) < int'(src));
                upd = 1'b1;
            end
            4'b1011: res = dst & src;
            4'b0101: res = 8'(255 - int'(dst));
            4'b1100: res = src;
            default: res = dst;
        endcase
        z = (res == 8'd0) && !c;
    endfunction

    function automatic void pushSnapshot();
        snap_t sn;
        for (int i = 0; i < 4; i++) begin
            sn.regs[i] = ref_regs[i];
        end
        sn.cf = ref_cf;
        sn.zf = ref_zf;
        sb_q.push_back(sn);
    endfunction

    function automatic void resetModel();
        for (int i = 0; i < 4; i++) begin
            ref_regs[i] = 8'd0;
        end
        ref_cf = 1'b0;
        ref_zf = 1'b0;
    endfunction

    // Called at a falling edge; returns at the falling edge after the beat transferred.
    task automatic applyStimulus(input logic [7:0] b, input int gap, output bit ok);
        ok = 1'b0;
        repeat (gap) @(negedge clk);
        ins       = b;
        ins_valid = 1'b1;
        for (int w = 0; w < 8 && !ins_ready; w++) @(negedge clk);
        if (!ins_ready) begin
            n_checks++;
            $display("[TB] FAIL handshake_timeout: ins_ready got 0, expected 1 within 8 cycles");
            ins_valid = 1'b0;
            return;
        end
        @(posedge clk);
        ok = 1'b1;
        @(negedge clk);
        ins_valid = 1'b0;
        ins       = 8'($urandom);
    endtask

    task automatic issueAlu(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rd, input int gap);
        bit         ok;
        logic [7:0] res;
        logic       upd, c, z;
        applyStimulus({op, rs, rd}, gap, ok);
        if (!ok) return;
        refExec(op, ref_regs[rs], ref_regs[rd], res, upd, c, z);
        ref_regs[rd] = res;
        if (upd) begin
            ref_cf = c;
            ref_zf = z;
        end
        pushSnapshot();
    endtask

    task automatic issueLdi(input logic [1:0] rd, input logic [7:0] imm, input int gap, input int imm_gap);
        bit ok;
        applyStimulus({4'b0000, 2'($urandom_range(0, 3)), rd}, gap, ok);
        if (!ok) return;
        applyStimulus(imm, imm_gap, ok);
        if (!ok) return;
        ref_regs[rd] = imm;
        pushSnapshot();
    endtask

    task automatic issueIllegal(input logic [7:0] b, input int gap);
        bit ok;
        applyStimulus(b, gap, ok);
        if (!ok) return;
        ill_expected++;
        checkOutput("ill_op_pulse", 32'(ill_op), 32'd1);
        checkOutput("ill_stays_idle", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("ill_op_clear", 32'(ill_op), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ins_ready"}, 32'(ins_ready), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_CF"}, 32'(cf), 32'd0);
        checkOutput({tag, "_ZF"}, 32'(zf), 32'd0);
        checkOutput({tag, "_M"}, 32'(m), 32'd0);
        checkOutput({tag, "_se"}, 32'(se), 32'd0);
        checkOutput({tag, "_S"}, 32'(s_bus), 32'd0);
        checkOutput({tag, "_D"}, 32'(d_bus), 32'd0);
        checkOutput({tag, "_ill_op"}, 32'(ill_op), 32'd0);
    endtask

    // Monitor: the cycle after any not-ready (EXEC) cycle, pop a snapshot and sweep the register file.
    initial begin : monitor
        bit    was_exec;
        snap_t expv;
        was_exec = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                was_exec = 1'b0;
                continue;
            end
            if (ill_op) ill_seen++;
            if (was_exec) begin
                checkOutput("exec_single_cycle", 32'(ins_ready), 32'd1);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_retire: got a retirement, expected none pending");
                end else begin
                    expv = sb_q.pop_front();
                    for (int i = 0; i < 4; i++) begin
                        dbg_sel = 2'(i);
                        #1;
                        checkOutput($sformatf("R%0d", i), 32'(dbg_data), 32'(expv.regs[i]));
                    end
                    checkOutput("CF", 32'(cf), 32'(expv.cf));
                    checkOutput("ZF", 32'(zf), 32'(expv.zf));
                end
            end
            was_exec = !ins_ready;
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation got stuck, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        bit ok;
        resetModel();
        repeat (3) @(negedge clk);
        checkResetState("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkResetState("after_reset");

        issueLdi(2'd1, 8'h05, 0, 0);
        issueLdi(2'd2, 8'h03, 0, 0);
        issueAlu(4'b1001, 2'd2, 2'd1, 0);

        issueLdi(2'd0, 8'h80, 0, 0);
        issueAlu(4'b1001, 2'd0, 2'd0, 0);
        issueLdi(2'd2, 8'h08, 0, 0);
        issueAlu(4'b0110, 2'd2, 2'd1, 0);
        issueAlu(4'b0110, 2'd2, 2'd0, 0);

        issueLdi(2'd3, 8'h0F, 0, 0);
        issueAlu(4'b0101, 2'd0, 2'd3, 0);
        issueAlu(4'b1011, 2'd2, 2'd3, 0);
        issueAlu(4'b1100, 2'd3, 2'd0, 0);
        issueAlu(4'b1010, 2'd1, 2'd2, 0);
        issueAlu(4'b0100, 2'd0, 2'd1, 1);

        issueIllegal(8'h35, 0);
        issueIllegal(8'h3A, 1);
        issueIllegal(8'hF0, 0);

        applyStimulus(8'h02, 0, ok);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("imm_wait_busy", 32'(busy), 32'd1);
            checkOutput("imm_wait_ready", 32'(ins_ready), 32'd1);
        end
        applyStimulus(8'hA5, 0, ok);
        ref_regs[2] = 8'hA5;
        pushSnapshot();

        applyStimulus(8'h01, 0, ok);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("imm_reset");
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        issueAlu(4'hA, 2'd1, 2'd1, 0);

        for (int n = 0; n < 300; n++) begin
            int kind;
            int gap;
            kind = int'($urandom_range(0, 9));
            gap  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (kind < 3) begin
                issueLdi(2'($urandom_range(0, 3)), 8'($urandom), gap, int'($urandom_range(0, 2)));
            end else if (kind == 3) begin
                issueIllegal({ill_ops[$urandom_range(0, 7)], 4'($urandom)}, gap);
            end else begin
                issueAlu(alu_ops[$urandom_range(0, 6)], 2'($urandom_range(0, 3)),
                         2'($urandom_range(0, 3)), gap);
            end
        end

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        checkOutput("ill_op_count", 32'(ill_seen), 32'(ill_expected));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
